// File: rtl/bank_drain_ctrl_if.sv
// Control/handshake bundle between the ping-pong bank drain scheduler and its
// writer, FIFO banks and downstream packer.
interface bank_drain_ctrl_if #(
    parameter int LEN_W = 13
);
    logic             enable;
    logic [LEN_W-1:0] packer_len;
    logic             wr_a;
    logic             wr_b;
    logic             out_ready;
    logic             rd_a;
    logic             rd_b;
    logic             out_valid;
    logic             out_bank;
    logic             frame_start;
    logic             frame_end;
    logic             overflow;
    logic [15:0]      frame_cnt;

    modport slave (
        input  enable, packer_len, wr_a, wr_b, out_ready,
        output rd_a, rd_b, out_valid, out_bank, frame_start, frame_end, overflow, frame_cnt
    );

    modport master (
        output enable, packer_len, wr_a, wr_b, out_ready,
        input  rd_a, rd_b, out_valid, out_bank, frame_start, frame_end, overflow, frame_cnt
    );
endinterface

// File: rtl/bank_drain_ctrl.sv
// Drains whole frames alternately from ping-pong banks A/B; data-side outputs lag the read by 1 cycle.
// out_ready low stalls reads in DRAIN; FLUSH discards leftovers regardless of out_ready.
module bank_drain_ctrl #(
    parameter int DEPTH = 4096,
    parameter int LEN_W = 13
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             ce_i,
    bank_drain_ctrl_if.slave bus
);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int LW   = LEN_W + 1;
    localparam int CMPW = (CW > LW) ? CW : LW;

    typedef enum logic [2:0] {IDLE, WAIT_A, DRAIN_A, WAIT_B, DRAIN_B, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] occ_a_q, occ_a_d, occ_b_q, occ_b_d;
    logic [LW-1:0] len_q, len_d, fcnt_q, fcnt_d;
    logic          out_valid_q, out_valid_d, out_bank_q, out_bank_d;
    logic          frame_start_q, frame_start_d, frame_end_q, frame_end_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          rd_a, rd_b, drain_rd, last_rd;
    logic          unused_ce;

    assign unused_ce = ce_i;

    function automatic logic [CW-1:0] occ_next(input logic [CW-1:0] occ, input logic wr, input logic rd);
        if (wr && !rd)
            return (occ == CW'(DEPTH)) ? occ : occ + CW'(1);
        if (rd && !wr)
            return occ - CW'(1);
        return occ;
    endfunction

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        fcnt_d   = fcnt_q;
        rd_a     = 1'b0;
        rd_b     = 1'b0;
        drain_rd = 1'b0;
        last_rd  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable && occ_a_q == '0 && occ_b_q == '0) begin
                    state_d = WAIT_A;
                    // A zero length means a full 2^LEN_W frame, matching the writer's len-1 wrap.
                    len_d   = (bus.packer_len == '0) ? (LW'(1) << LEN_W) : LW'(bus.packer_len);
                end else if (!bus.enable && (occ_a_q != '0 || occ_b_q != '0)) begin
                    state_d = FLUSH;
                end
            end
            WAIT_A: begin
                if (CMPW'(occ_a_q) >= CMPW'(len_q)) begin
                    state_d = DRAIN_A;
                    fcnt_d  = '0;
                end else if (!bus.enable) begin
                    state_d = FLUSH;
                end
            end
            WAIT_B: begin
                if (CMPW'(occ_b_q) >= CMPW'(len_q)) begin
                    state_d = DRAIN_B;
                    fcnt_d  = '0;
                end else if (!bus.enable) begin
                    state_d = FLUSH;
                end
            end
            DRAIN_A: rd_a = bus.out_ready;
            DRAIN_B: rd_b = bus.out_ready;
            FLUSH: begin
                rd_a = (occ_a_q != '0);
                rd_b = (occ_b_q != '0);
                if (occ_a_q == '0 && occ_b_q == '0 && !bus.wr_a && !bus.wr_b)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q == DRAIN_A || state_q == DRAIN_B) begin
            drain_rd = bus.out_ready;
            last_rd  = drain_rd && (fcnt_q == len_q - LW'(1));
            if (drain_rd)
                fcnt_d = fcnt_q + LW'(1);
            // An enable drop mid-frame only takes effect once the frame is complete.
            if (last_rd)
                state_d = !bus.enable ? FLUSH : ((state_q == DRAIN_A) ? WAIT_B : WAIT_A);
        end
    end

    always_comb begin
        occ_a_d       = occ_next(occ_a_q, bus.wr_a, rd_a);
        occ_b_d       = occ_next(occ_b_q, bus.wr_b, rd_b);
        overflow_d    = overflow_q
                      | (bus.wr_a && !rd_a && occ_a_q == CW'(DEPTH))
                      | (bus.wr_b && !rd_b && occ_b_q == CW'(DEPTH));
        out_valid_d   = drain_rd;
        out_bank_d    = drain_rd ? (state_q == DRAIN_B) : out_bank_q;
        frame_start_d = drain_rd && (fcnt_q == '0);
        frame_end_d   = last_rd;
        frame_cnt_d   = frame_cnt_q + {15'd0, last_rd};
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q       <= IDLE;
            occ_a_q       <= '0;
            occ_b_q       <= '0;
            len_q         <= '0;
            fcnt_q        <= '0;
            out_valid_q   <= 1'b0;
            out_bank_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            overflow_q    <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            occ_a_q       <= occ_a_d;
            occ_b_q       <= occ_b_d;
            len_q         <= len_d;
            fcnt_q        <= fcnt_d;
            out_valid_q   <= out_valid_d;
            out_bank_q    <= out_bank_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            overflow_q    <= overflow_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign bus.rd_a        = rd_a;
    assign bus.rd_b        = rd_b;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_bank    = out_bank_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_end   = frame_end_q;
    assign bus.overflow    = overflow_q;
    assign bus.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_bank_drain_ctrl.sv
// Directed bench for bank_drain_ctrl: cycle table for the basic ping-pong, hand sequences for the rest.
module tb_bank_drain_ctrl;
    localparam int LEN_W = 13;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ce    = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bank_drain_ctrl_if #(.LEN_W(LEN_W)) bi ();
    bank_drain_ctrl_if #(.LEN_W(LEN_W)) bb ();

    bank_drain_ctrl #(.DEPTH(16), .LEN_W(LEN_W)) dut (
        .clk_i(clk), .reset_i(rst_n), .ce_i(ce), .bus(bi)
    );
    bank_drain_ctrl #(.DEPTH(8192), .LEN_W(LEN_W)) dut_big (
        .clk_i(clk), .reset_i(rst_n), .ce_i(ce), .bus(bb)
    );

    // {enable, wr_a, wr_b, out_ready} -> {rd_a, rd_b, out_valid, out_bank&valid, frame_start, frame_end}, frame_cnt
    typedef struct packed {
        logic [3:0]  in;
        logic [5:0]  o;
        logic [15:0] fc;
    } vec_t;
    vec_t vecs [17];

    always @(negedge clk) begin
        if (rst_n) begin
            assert (!((bi.rd_a && dut.occ_a_q == 0) || (bi.rd_b && dut.occ_b_q == 0)))
                else $error("FAIL rd_on_empty: occ_a=%0d occ_b=%0d", dut.occ_a_q, dut.occ_b_q);
            assert (!(bi.rd_a && bi.rd_b && dut.state_q != 3'd5))
                else $error("FAIL dual_rd: rd_a and rd_b both high outside FLUSH");
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit a, input bit b, input int n);
        repeat (n) begin
            bi.wr_a = a;
            bi.wr_b = b;
            tick();
        end
        bi.wr_a = 1'b0;
        bi.wr_b = 1'b0;
    endtask

    task automatic go_idle();
        bi.enable = 1'b0;
        bi.wr_a   = 1'b0;
        bi.wr_b   = 1'b0;
        repeat (4) tick();
    endtask

    task automatic start(input int len);
        bi.packer_len = LEN_W'(len);
        bi.enable     = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bi.enable = 1'b0; bi.wr_a = 1'b0; bi.wr_b = 1'b0; bi.out_ready = 1'b0;
        tick();
    endtask

    initial begin
        int nrd, nrdb, nbad, nval, nbv, fs_at, fe_at, first;
        bit found;

        vecs[0]  = '{4'b1001, 6'b000000, 16'd0};
        for (int i = 1; i <= 4; i++) vecs[i] = '{4'b1101, 6'b000000, 16'd0};
        vecs[5]  = '{4'b1011, 6'b000000, 16'd0};
        vecs[6]  = '{4'b1011, 6'b100000, 16'd0};
        vecs[7]  = '{4'b1011, 6'b101010, 16'd0};
        vecs[8]  = '{4'b1011, 6'b101000, 16'd0};
        vecs[9]  = '{4'b1001, 6'b101000, 16'd0};
        vecs[10] = '{4'b1001, 6'b001001, 16'd1};
        vecs[11] = '{4'b1001, 6'b010000, 16'd1};
        vecs[12] = '{4'b1001, 6'b011110, 16'd1};
        vecs[13] = '{4'b1001, 6'b011100, 16'd1};
        vecs[14] = '{4'b1001, 6'b011100, 16'd1};
        vecs[15] = '{4'b1001, 6'b001101, 16'd2};
        vecs[16] = '{4'b1001, 6'b000000, 16'd2};

        bi.enable = 1'b0; bi.packer_len = '0; bi.wr_a = 1'b0; bi.wr_b = 1'b0; bi.out_ready = 1'b0;
        bb.enable = 1'b0; bb.packer_len = '0; bb.wr_a = 1'b0; bb.wr_b = 1'b0; bb.out_ready = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", {bi.rd_a, bi.rd_b, bi.out_valid, bi.out_bank, bi.frame_start,
                              bi.frame_end, bi.overflow, bi.frame_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic ping-pong, L=4
        bi.packer_len = LEN_W'(4);
        for (int i = 0; i < 17; i++) begin
            {bi.enable, bi.wr_a, bi.wr_b, bi.out_ready} = vecs[i].in;
            #4;
            chk($sformatf("pingpong[%0d]", i),
                {10'd0, bi.rd_a, bi.rd_b, bi.out_valid, bi.out_valid & bi.out_bank,
                 bi.frame_start, bi.frame_end, bi.frame_cnt},
                {10'd0, vecs[i].o, vecs[i].fc});
            tick();
        end

        // Backpressure, L=8, out_ready alternating
        go_idle();
        start(8);
        bi.out_ready = 1'b0;
        wr(1, 0, 8);
        nrd = 0; nbad = 0; nval = 0; fs_at = 0; fe_at = 0;
        for (int c = 0; c < 40; c++) begin
            bi.out_ready = ((c % 2) == 0);
            #4;
            if (bi.rd_a) begin nrd++; if (!bi.out_ready) nbad++; end
            if (bi.out_valid) begin
                nval++;
                if (bi.frame_start) fs_at = nval;
                if (bi.frame_end) fe_at = nval;
            end
            tick();
        end
        chk("bp_reads", nrd, 8);
        chk("bp_read_without_ready", nbad, 0);
        chk("bp_valids", nval, 8);
        chk("bp_start_pos", fs_at, 1);
        chk("bp_end_pos", fe_at, 8);
        chk("bp_frame_cnt", bi.frame_cnt, 3);

        // Wait for a full frame, L=16
        go_idle();
        start(16);
        bi.out_ready = 1'b1;
        wr(1, 0, 15);
        nrd = 0;
        repeat (5) begin
            #4;
            if (bi.rd_a) nrd++;
            tick();
        end
        chk("wait15_no_read", nrd, 0);
        wr(1, 0, 1);
        #4;
        chk("wait16_eval_cycle_rd", bi.rd_a, 0);
        tick();
        #4;
        chk("wait16_drain_rd", bi.rd_a, 1);
        repeat (22) tick();
        chk("wait16_frame_cnt", bi.frame_cnt, 4);

        // Disable mid-frame, then FLUSH of bank B
        go_idle();
        start(8);
        bi.out_ready = 1'b0;
        wr(1, 0, 8);
        wr(0, 1, 5);
        bi.out_ready = 1'b1;
        nrd = 0; nrdb = 0; nval = 0; nbv = 0;
        for (int c = 0; c < 50; c++) begin
            if (nrd >= 3) bi.enable = 1'b0;
            #4;
            if (bi.rd_a) nrd++;
            if (bi.rd_b) nrdb++;
            if (bi.out_valid) begin nval++; if (bi.out_bank) nbv++; end
            tick();
        end
        chk("dis_reads_a", nrd, 8);
        chk("dis_flush_reads_b", nrdb, 5);
        chk("dis_valids", nval, 8);
        chk("dis_valid_from_b", nbv, 0);
        chk("dis_occ", {dut.occ_a_q, dut.occ_b_q}, 0);
        chk("dis_idle", dut.state_q, 0);
        chk("dis_frame_cnt", bi.frame_cnt, 5);

        // Re-enable starts on bank A even when B fills first
        start(8);
        wr(0, 1, 8);
        wr(1, 0, 8);
        first = -1; nrd = 0;
        for (int c = 0; c < 40; c++) begin
            #4;
            if (first < 0 && (bi.rd_a || bi.rd_b)) first = bi.rd_b;
            if (bi.rd_a || bi.rd_b) nrd++;
            tick();
        end
        chk("reen_first_bank", first, 0);
        chk("reen_reads", nrd, 16);
        chk("reen_frame_cnt", bi.frame_cnt, 7);

        // Overflow on 17th write into a 16-deep bank
        go_idle();
        start(16);
        bi.out_ready = 1'b0;
        wr(1, 0, 16);
        chk("ovf_before", bi.overflow, 0);
        wr(1, 0, 1);
        chk("ovf_set", bi.overflow, 1);
        chk("ovf_occ_sat", dut.occ_a_q, 16);
        repeat (5) tick();
        chk("ovf_sticky", bi.overflow, 1);

        // L=1: every word is both start and end
        do_reset();
        start(1);
        bi.out_ready = 1'b1;
        wr(1, 1, 2);
        nval = 0; nbad = 0;
        for (int c = 0; c < 20; c++) begin
            #4;
            if (bi.out_valid) begin nval++; if (!(bi.frame_start && bi.frame_end)) nbad++; end
            tick();
        end
        chk("len1_valids", nval, 4);
        chk("len1_not_start_end", nbad, 0);
        chk("len1_frame_cnt", bi.frame_cnt, 4);

        // Reset asserted during DRAIN_B
        do_reset();
        start(8);
        bi.out_ready = 1'b1;
        wr(1, 0, 8);
        wr(0, 1, 8);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            #4;
            if (dut.state_q == 3'd4 && bi.rd_b && bi.out_valid) found = 1'b1;
            else tick();
        end
        chk("drain_b_reached", found, 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {bi.rd_a, bi.rd_b, bi.out_valid, bi.out_bank, bi.frame_start,
                                    bi.frame_end, bi.overflow, bi.frame_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // packer_len=0 -> 8192-word frame on the deep instance
        bb.packer_len = '0;
        bb.enable     = 1'b1;
        bb.out_ready  = 1'b1;
        tick();
        repeat (8192) begin
            bb.wr_a = 1'b1;
            tick();
        end
        bb.wr_a = 1'b0;
        nval = 0; fs_at = 0; fe_at = 0;
        for (int c = 0; c < 9000 && fe_at == 0; c++) begin
            #4;
            if (bb.out_valid) begin
                nval++;
                if (bb.frame_start && fs_at == 0) fs_at = nval;
                if (bb.frame_end) fe_at = nval;
            end
            tick();
        end
        chk("len0_start_pos", fs_at, 1);
        chk("len0_end_pos", fe_at, 8192);
        chk("len0_frame_cnt", bb.frame_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
